// File: rtl/region_select_ctrl.sv
// rtl/region_select_ctrl.sv - per-frame glove region selection with debounced commit
module region_select_ctrl #(
    parameter int THRESH         = 2000,
    parameter int CONFIRM_FRAMES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_valid,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic       glove_hit,
    input  logic       frame_end,
    output logic       red_flag,
    output logic       green_flag,
    output logic       blue_flag,
    output logic       yellow_flag,
    output logic [1:0] region_id,
    output logic       region_valid,
    output logic       frame_done
);

    localparam logic [16:0] CNT_MAX   = 17'h1ffff;
    localparam logic [16:0] THRESH_C  = 17'(THRESH);
    localparam logic [2:0]  CONFIRM_C = 3'(CONFIRM_FRAMES);

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        EVAL   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t      state;
    logic [16:0] hit_cnt [4];

    // Scan bookkeeping for the frame being evaluated
    logic [1:0]  scan_idx;
    logic [16:0] best_cnt;
    logic        best_found;
    logic [1:0]  best_idx;

    // Debounce history: previous candidate and how many frames in a row it held
    logic        prev_found;
    logic [1:0]  prev_idx;
    logic [2:0]  streak;

    logic [3:0]  flags;

    logic        in_range;
    logic [1:0]  pix_region;
    logic        count_en;
    logic [16:0] scan_cnt;
    logic        scan_hit;
    logic        same_cand;
    logic [2:0]  next_streak;
    logic        commit;

    // Map the pixel column onto one of four vertical stripes
    always_comb begin
        in_range = (x_pos < 10'd640) && (y_pos < 10'd480);
        if (x_pos < 10'd160) begin
            pix_region = 2'd0;
        end else if (x_pos < 10'd320) begin
            pix_region = 2'd1;
        end else if (x_pos < 10'd480) begin
            pix_region = 2'd2;
        end else begin
            pix_region = 2'd3;
        end
        count_en = pixel_valid && glove_hit && in_range && (state == ACCUM);
    end

    // Scan compare and debounce decision for the frame under evaluation
    always_comb begin
        scan_cnt  = hit_cnt[scan_idx];
        // Strict greater-than keeps the lowest index on ties
        scan_hit  = (scan_cnt >= THRESH_C) && (scan_cnt > best_cnt);
        same_cand = (best_found == prev_found) && (!best_found || (best_idx == prev_idx));
        if (same_cand) begin
            next_streak = (streak >= CONFIRM_C) ? CONFIRM_C : streak + 3'd1;
        end else begin
            next_streak = 3'd1;
        end
        commit = (next_streak == CONFIRM_C);
    end

    // Per-region hit counters: count only while accumulating, clear once a decision is applied
    always_ff @(posedge clk) begin
        if (reset || (state == UPDATE)) begin
            for (int i = 0; i < 4; i++) begin
                hit_cnt[i] <= '0;
            end
        end else if (count_en && (hit_cnt[pix_region] != CNT_MAX)) begin
            hit_cnt[pix_region] <= hit_cnt[pix_region] + 17'd1;
        end
    end

    // Frame FSM: accumulate, scan four regions, then apply the debounced decision
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            scan_idx     <= 2'd0;
            best_cnt     <= '0;
            best_found   <= 1'b0;
            best_idx     <= 2'd0;
            prev_found   <= 1'b0;
            prev_idx     <= 2'd0;
            streak       <= 3'd0;
            flags        <= 4'd0;
            region_id    <= 2'd0;
            region_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ACCUM: begin
                    if (frame_end) begin
                        state      <= EVAL;
                        scan_idx   <= 2'd0;
                        best_cnt   <= '0;
                        best_found <= 1'b0;
                        best_idx   <= 2'd0;
                    end
                end
                EVAL: begin
                    if (scan_hit) begin
                        best_cnt   <= scan_cnt;
                        best_found <= 1'b1;
                        best_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + 2'd1;
                    if (scan_idx == 2'd3) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    streak     <= next_streak;
                    prev_found <= best_found;
                    prev_idx   <= best_found ? best_idx : 2'd0;
                    if (commit) begin
                        if (best_found) begin
                            flags        <= 4'b0001 << best_idx;
                            region_id    <= best_idx;
                            region_valid <= 1'b1;
                        end else begin
                            flags        <= 4'd0;
                            region_id    <= 2'd0;
                            region_valid <= 1'b0;
                        end
                    end
                    frame_done <= 1'b1;
                    state      <= ACCUM;
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign red_flag    = flags[0];
    assign green_flag  = flags[1];
    assign blue_flag   = flags[2];
    assign yellow_flag = flags[3];

endmodule

// File: tb/tb_region_select_ctrl.sv
// tb/tb_region_select_ctrl.sv - scoreboard bench for region_select_ctrl
module tb_region_select_ctrl;

    localparam int THRESH = 2000;

    typedef struct {
        int flags;
        int id;
        int valid;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_valid = 1'b0;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic       glove_hit = 1'b0;
    logic       frame_end = 1'b0;

    logic       r0, g0, b0, y0, v0, fd0;
    logic [1:0] id0;
    logic       r1, g1, b1, y1, v1, fd1;
    logic [1:0] id1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int mcnt [4];
    int hist [$];
    int committed0 = -1;
    int committed1 = -1;
    exp_t q0 [$];
    exp_t q1 [$];

    region_select_ctrl #(.THRESH(THRESH), .CONFIRM_FRAMES(3)) u_dut0 (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .x_pos(x_pos), .y_pos(y_pos),
        .glove_hit(glove_hit), .frame_end(frame_end),
        .red_flag(r0), .green_flag(g0), .blue_flag(b0), .yellow_flag(y0),
        .region_id(id0), .region_valid(v0), .frame_done(fd0)
    );

    region_select_ctrl #(.THRESH(THRESH), .CONFIRM_FRAMES(1)) u_dut1 (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .x_pos(x_pos), .y_pos(y_pos),
        .glove_hit(glove_hit), .frame_end(frame_end),
        .red_flag(r1), .green_flag(g1), .blue_flag(b1), .yellow_flag(y1),
        .region_id(id1), .region_valid(v1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Winner: the largest count, lowest index among equals, none if it misses the threshold
    function automatic int frame_candidate();
        int mx = 0;
        for (int r = 0; r < 4; r++) if (mcnt[r] > mx) mx = mcnt[r];
        if (mx < THRESH) return -1;
        for (int r = 0; r < 4; r++) if (mcnt[r] == mx) return r;
        return -1;
    endfunction

    // Commit when the last c candidates since reset all agree
    function automatic int debounce(input int c, input int cur);
        int last;
        if (hist.size() < c) return cur;
        last = hist[hist.size() - 1];
        for (int k = 1; k <= c; k++) if (hist[hist.size() - k] != last) return cur;
        return last;
    endfunction

    function automatic exp_t make_exp(input int committed, input int at);
        exp_t e;
        e.flags = (committed < 0) ? 0 : (1 << committed);
        e.id    = (committed < 0) ? 0 : committed;
        e.valid = (committed < 0) ? 0 : 1;
        e.cyc   = at;
        return e;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 4; r++) mcnt[r] = 0;
        hist.delete();
        committed0 = -1;
        committed1 = -1;
    endtask

    task automatic drive_pix(input bit v, input int x, input int y, input bit h);
        @(negedge clk);
        pixel_valid = v;
        x_pos = 10'(x);
        y_pos = 10'(y);
        glove_hit = h;
        if (v && h && x < 640 && y < 480) mcnt[x / 160]++;
    endtask

    task automatic hit_run(input int x, input int n);
        for (int i = 0; i < n; i++) drive_pix(1'b1, x, $urandom_range(479), 1'b1);
    endtask

    task automatic noise_pix();
        case ($urandom_range(3))
            0: drive_pix(1'b0, $urandom_range(639), $urandom_range(479), 1'b1);
            1: drive_pix(1'b1, $urandom_range(639), $urandom_range(479), 1'b0);
            2: drive_pix(1'b1, $urandom_range(1023, 640), $urandom_range(479), 1'b1);
            default: drive_pix(1'b1, $urandom_range(639), $urandom_range(1023, 480), 1'b1);
        endcase
    endtask

    // Close a frame; optionally count a pixel on the frame_end edge or repeat frame_end inside EVAL
    task automatic end_frame(input bit with_pix, input bit dup_fe);
        int cand;
        int x;
        @(negedge clk);
        frame_end = 1'b1;
        if (with_pix) begin
            x = $urandom_range(639);
            pixel_valid = 1'b1;
            glove_hit = 1'b1;
            x_pos = 10'(x);
            y_pos = 10'($urandom_range(479));
            mcnt[x / 160]++;
        end else begin
            pixel_valid = 1'b0;
        end
        cand = frame_candidate();
        hist.push_back(cand);
        committed0 = debounce(3, committed0);
        committed1 = debounce(1, committed1);
        q0.push_back(make_exp(committed0, cyc + 6));
        q1.push_back(make_exp(committed1, cyc + 6));
        for (int r = 0; r < 4; r++) mcnt[r] = 0;
        @(negedge clk);
        frame_end = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clk);
        if (dup_fe) frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        cmp({tag, "_flags0"}, int'({y0, b0, g0, r0}), 0);
        cmp({tag, "_id0"}, int'(id0), 0);
        cmp({tag, "_valid0"}, int'(v0), 0);
        cmp({tag, "_done0"}, int'(fd0), 0);
        cmp({tag, "_flags1"}, int'({y1, b1, g1, r1}), 0);
        cmp({tag, "_valid1"}, int'(v1), 0);
    endtask

    // Monitor for the three-frame-debounce instance
    always @(negedge clk) begin
        if (!reset && fd0) begin
            if (q0.size() == 0) begin
                cmp("unexpected_done0", 1, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                cmp("flags0", int'({y0, b0, g0, r0}), e.flags);
                cmp("region_id0", int'(id0), e.id);
                cmp("region_valid0", int'(v0), e.valid);
                cmp("done_cycle0", cyc, e.cyc);
            end
        end
    end

    // Monitor for the single-frame-confirm instance
    always @(negedge clk) begin
        if (!reset && fd1) begin
            if (q1.size() == 0) begin
                cmp("unexpected_done1", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                cmp("flags1", int'({y1, b1, g1, r1}), e.flags);
                cmp("region_id1", int'(id1), e.id);
                cmp("region_valid1", int'(v1), e.valid);
                cmp("done_cycle1", cyc, e.cyc);
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;

        // Three green frames commit green only on the third decision
        for (int f = 0; f < 3; f++) begin
            hit_run(200, 5000);
            end_frame(1'b0, 1'b0);
        end

        // Alternating blue/green never reaches three in a row
        hit_run(400, 4000); end_frame(1'b0, 1'b0);
        hit_run(200, 4000); end_frame(1'b0, 1'b0);
        hit_run(400, 4000); end_frame(1'b0, 1'b0);

        // Just-below-threshold in every region, three times, clears the commit
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) hit_run(r * 160 + 80, 1999);
            end_frame(1'b0, 1'b0);
        end

        // Tie between red and yellow resolves to red
        hit_run(50, 3000);
        hit_run(600, 3000);
        end_frame(1'b0, 1'b0);

        // Randomised frames around the threshold with rejected samples mixed in
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 4; r++) begin
                int n;
                n = $urandom_range(2400);
                for (int i = 0; i < n; i++) begin
                    drive_pix(1'b1, r * 160 + $urandom_range(159), $urandom_range(479), 1'b1);
                    if ($urandom_range(7) == 0) noise_pix();
                end
            end
            end_frame(1'($urandom_range(1)), 1'b0);
        end

        // Only out-of-range hits, plus a frame_end that lands during EVAL
        for (int i = 0; i < 60; i++) begin
            drive_pix(1'b1, $urandom_range(700, 640), $urandom_range(479), 1'b1);
            drive_pix(1'b1, $urandom_range(639), 480, 1'b1);
        end
        end_frame(1'b0, 1'b1);

        // Two yellow frames, then reset on the third edge of the scan that would commit
        for (int f = 0; f < 2; f++) begin
            hit_run(560, 2100);
            end_frame(1'b0, 1'b0);
        end
        hit_run(560, 2100);
        @(negedge clk);
        frame_end = 1'b1;
        pixel_valid = 1'b0;
        @(negedge clk);
        frame_end = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b0;
        model_clear();
        repeat (8) @(negedge clk);
        check_idle("post_abort");

        // Counting resumes from zero after the aborted evaluation
        hit_run(560, 2100);
        end_frame(1'b0, 1'b0);

        repeat (4) @(negedge clk);
        cmp("q0_drained", q0.size(), 0);
        cmp("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/region_select_ctrl.md
REGION_SELECT_CTRL -- requirements
Module: region_select_ctrl

Interface
REQ-001 Parameter THRESH, default 2000: minimum glove-pixel count for a region to be a candidate.
REQ-002 Parameter CONFIRM_FRAMES, default 3, legal range 1..7: consecutive identical frame decisions required to commit.
REQ-003 clk  in  1  single system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pixel_valid  in  1  current x_pos/y_pos/glove_hit sample is valid.
REQ-006 x_pos  in  10  pixel column, 0..639 active.
REQ-007 y_pos  in  10  pixel row, 0..479 active.
REQ-008 glove_hit  in  1  pixel classified as glove colour.
REQ-009 frame_end  in  1  one-cycle pulse after the last active pixel of a frame.
REQ-010 red_flag, green_flag, blue_flag, yellow_flag  out  1 each  committed region; at most one high; all low means no region.
REQ-011 region_id  out  2  index of the committed region: 0 red, 1 green, 2 blue, 3 yellow; 0 when no region.
REQ-012 region_valid  out  1  high when a region is committed (OR of the four flags).
REQ-013 frame_done  out  1  one-cycle pulse when the frame decision is applied.

Function
REQ-014 Region map: x 0..159 -> 0; 160..319 -> 1; 320..479 -> 2; 480..639 -> 3.
REQ-015 Samples with x_pos >= 640 or y_pos >= 480 are ignored.
REQ-016 Four 17-bit hit counters; a counter increments when pixel_valid && glove_hit && in range && state == ACCUM; each counter saturates at 131071.
REQ-017 FSM states: ACCUM, EVAL, UPDATE.
REQ-018 ACCUM -> EVAL on frame_end; a qualifying pixel sampled on the same edge as frame_end is counted in the closing frame.
REQ-019 EVAL lasts exactly 4 cycles and scans regions 0..3 in order, one per cycle, tracking best count and best index.
REQ-020 A region becomes best only if its count >= THRESH and strictly > the current best count, so ties go to the lowest index.
REQ-021 The candidate is "none" when no region reaches THRESH.
REQ-022 EVAL -> UPDATE after the 4th scan cycle; UPDATE lasts 1 cycle, then the FSM returns to ACCUM with all four counters cleared.
REQ-023 Pixels and frame_end arriving in EVAL or UPDATE are dropped; no frame is queued.
REQ-024 UPDATE debounce: if the candidate equals the stored previous candidate, the 3-bit streak increments, saturating at CONFIRM_FRAMES.
REQ-025 UPDATE debounce, otherwise: streak = 1 and previous candidate = candidate.
REQ-026 When the updated streak equals CONFIRM_FRAMES, the committed region becomes the candidate; a committed "none" clears all flags. Otherwise the committed region is unchanged.
REQ-027 Latency: frame_end sampled on edge E0; scan on E1..E4; update on E5; new outputs and frame_done=1 are visible in the cycle after E5, and frame_done is low again after E6.
REQ-028 With CONFIRM_FRAMES=1, the committed region follows each frame's candidate directly.
REQ-029 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-030 On reset the block enters ACCUM, clears counters, streak and previous candidate (= none), and drives all flags, region_id, region_valid and frame_done to 0.
REQ-031 Reset asserted in any state, including mid-EVAL, aborts the evaluation with no output update and takes priority over frame_end.

Verification
REQ-032 After reset, 3 frames with 5000 hits at x=200 and frame_end -> green_flag=1, region_id=1 after the 3rd frame_done and not before.
REQ-033 One frame with 3000 hits at x=50 and 3000 at x=600 (tie) -> candidate red; with CONFIRM_FRAMES=1, red_flag=1.
REQ-034 Green committed, then a frame with 1999 hits in every region, repeated 3 frames -> all flags 0 and region_valid=0 after the 3rd.
REQ-035 Green committed, then blue, green, blue frames (each 4000 hits) -> green remains committed; frame_done pulses 3 times.
REQ-036 Hits at x=640..700 and y=480 only, plus a second frame_end during EVAL -> counters stay 0 and exactly one frame_done pulse, 6 cycles after the first frame_end.
REQ-037 Reset asserted on E3 of an EVAL that would commit yellow -> no frame_done, all outputs 0, and counting restarts in ACCUM.
